// File: rtl/asc_dec_loader.sv
// Frame loader: collects N 4-bit elements in arrival order into a packed frame
// and presents it with odd/even element counts until the downstream consumes it.
module asc_dec_loader #(
    parameter int N  = 10,
    parameter int CW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [0:N*4-1] out_bus,
    output logic [CW-1:0]  odd_cnt,
    output logic [CW-1:0]  even_cnt,
    output logic           dbg_state
);

    localparam int            IW       = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [IW-1:0]   r_idx;
    logic [0:N*4-1]  r_bus;
    logic [CW-1:0]   r_odd;
    logic [CW-1:0]   r_even;
    logic            w_accept;
    logic            w_last;
    logic            w_release;

    // Handshake: an element transfers on a rising edge where in_valid && in_ready
    // (and no flush); a frame transfers where out_valid && out_ready. Neither
    // valid may depend on the matching ready, and data is held while valid waits.
    assign w_accept  = in_valid && in_ready && !flush;
    assign w_last    = (r_idx == LAST_IDX);
    assign w_release = (r_state == S_FULL) && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = S_FILL;
        end else begin
            case (r_state)
                S_FILL: if (w_accept && w_last) w_next_state = S_FULL;
                S_FULL: if (out_ready)          w_next_state = S_FILL;
                default:                        w_next_state = S_FILL;
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dbg_state = r_state;
        case (r_state)
            S_FILL:  in_ready  = 1'b1;
            S_FULL:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // out_bus is never cleared except by reset; a new frame overwrites it in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx  <= '0;
            r_bus  <= '0;
            r_odd  <= '0;
            r_even <= '0;
        end else if (flush) begin
            r_idx  <= '0;
            r_odd  <= '0;
            r_even <= '0;
        end else if (w_accept) begin
            r_bus[{r_idx, 2'b00} +: 4] <= in_data;
            if (in_data[0]) begin
                r_odd <= r_odd + 1'b1;
            end else begin
                r_even <= r_even + 1'b1;
            end
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end else if (w_release) begin
            r_odd  <= '0;
            r_even <= '0;
        end
    end

    assign out_bus  = r_bus;
    assign odd_cnt  = r_odd;
    assign even_cnt = r_even;

endmodule

// File: tb/tb_asc_dec_loader.sv
// Self-checking bench for asc_dec_loader: constant vector table, directed corner
// sequences and a randomized run against a frame-level reference model.
module tb_asc_dec_loader;

    localparam int N  = 10;
    localparam int CW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [3:0]     in_data = 4'h0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [0:N*4-1] out_bus;
    logic [CW-1:0]  odd_cnt;
    logic [CW-1:0]  even_cnt;
    logic           dbg_state;

    logic           rst2 = 1'b1;
    logic           flush2 = 1'b0;
    logic           in_valid2 = 1'b0;
    logic           in_ready2;
    logic [3:0]     in_data2 = 4'h0;
    logic           out_valid2;
    logic           out_ready2 = 1'b0;
    logic [0:7]     out_bus2;
    logic [1:0]     odd_cnt2;
    logic [1:0]     even_cnt2;
    logic           dbg_state2;

    asc_dec_loader #(.N(N), .CW(CW)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus),
        .odd_cnt(odd_cnt), .even_cnt(even_cnt), .dbg_state(dbg_state)
    );

    asc_dec_loader #(.N(2), .CW(2)) u_dut2 (
        .clk(clk), .rst(rst2), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_bus(out_bus2),
        .odd_cnt(odd_cnt2), .even_cnt(even_cnt2), .dbg_state(dbg_state2)
    );

    // ---------------- scoreboard / reference model ----------------
    // exp_q holds the elements accepted into the current frame, in order.
    logic [3:0] exp_q[$];
    logic [3:0] m_bus[N];
    logic       m_full = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic f, input logic v,
                                input logic [3:0] d, input logic ordy);
        if (r) begin
            exp_q.delete();
            m_full = 1'b0;
            for (int k = 0; k < N; k++) m_bus[k] = 4'h0;
        end else if (f) begin
            exp_q.delete();
            m_full = 1'b0;
        end else if (m_full) begin
            if (ordy) begin
                m_full = 1'b0;
                exp_q.delete();
            end
        end else if (v) begin
            m_bus[exp_q.size()] = d;
            exp_q.push_back(d);
            if (exp_q.size() == N) m_full = 1'b1;
        end
    endtask

    task automatic compare_model();
        int             n_odd;
        logic [0:N*4-1] eb;
        n_odd = 0;
        foreach (exp_q[k]) if (exp_q[k][0]) n_odd++;
        for (int k = 0; k < N; k++) eb[k*4 +: 4] = m_bus[k];
        check("model_out_valid", out_valid, m_full);
        check("model_in_ready", in_ready, !m_full);
        check("model_dbg_state", dbg_state, m_full);
        check("model_odd_cnt", odd_cnt, n_odd);
        check("model_even_cnt", even_cnt, exp_q.size() - n_odd);
        check("model_out_bus", out_bus, eb);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic f, input logic v,
                        input logic [3:0] d, input logic ordy);
        rst       = r;
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
        model_update(r, f, v, d, ordy);
        compare_model();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_out_bus"}, out_bus, 40'h0);
        check({tag, "_odd_cnt"}, odd_cnt, 4'd0);
        check({tag, "_even_cnt"}, even_cnt, 4'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic           v;
        logic [3:0]     d;
        logic           ordy;
        logic           exp_valid;
        logic           exp_ready;
        logic [CW-1:0]  exp_odd;
        logic [CW-1:0]  exp_even;
        logic [0:N*4-1] exp_bus;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 40'h9000000000};
        vecs[1]  = '{1'b1, 4'h8, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 40'h9800000000};
        vecs[2]  = '{1'b1, 4'h7, 1'b0, 1'b0, 1'b1, 4'd2, 4'd1, 40'h9870000000};
        vecs[3]  = '{1'b1, 4'h6, 1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 40'h9876000000};
        vecs[4]  = '{1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 40'h9876500000};
        vecs[5]  = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 40'h9876540000};
        vecs[6]  = '{1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 4'd4, 4'd3, 40'h9876543000};
        vecs[7]  = '{1'b1, 4'h2, 1'b0, 1'b0, 1'b1, 4'd4, 4'd4, 40'h9876543200};
        vecs[8]  = '{1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 4'd5, 4'd4, 40'h9876543210};
        vecs[9]  = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 4'd5, 4'd5, 40'h9876543210};
        vecs[10] = '{1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 4'd5, 4'd5, 40'h9876543210};
        vecs[11] = '{1'b1, 4'hB, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 40'h9876543210};
        vecs[12] = '{1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 40'hC876543210};

        // reset
        step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'h5, 1'b1);
        check_reset_state("reset");

        // basic frame 9..0, then hold, release and first element of next frame
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 1'b0, vecs[i].v, vecs[i].d, vecs[i].ordy);
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_odd_cnt", i), odd_cnt, vecs[i].exp_odd);
            check($sformatf("vec%0d_even_cnt", i), even_cnt, vecs[i].exp_even);
            check($sformatf("vec%0d_out_bus", i), out_bus, vecs[i].exp_bus);
        end

        // backpressure: complete C,1..9 then hold out_ready low for 20 cycles
        for (int i = 1; i <= 9; i++) step(1'b0, 1'b0, 1'b1, 4'(i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 1'(i % 2), 4'hF, 1'b0);
            check("bp_out_bus", out_bus, 40'hC123456789);
            check("bp_odd_cnt", odd_cnt, 4'd5);
            check("bp_even_cnt", even_cnt, 4'd5);
            check("bp_out_valid", out_valid, 1'b1);
        end
        step(1'b0, 1'b0, 1'b1, 4'h7, 1'b1);
        check("bp_release_valid", out_valid, 1'b0);
        check("bp_release_ready", in_ready, 1'b1);
        check("bp_release_odd", odd_cnt, 4'd0);
        step(1'b0, 1'b0, 1'b1, 4'hE, 1'b0);
        check("bp_next_first", out_bus, 40'hE123456789);

        // gapped input of odd values
        step(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) step(1'b0, 1'b0, 1'b1, 4'((2 * (i / 2) + 1) % 16), 1'b0);
            else            step(1'b0, 1'b0, 1'b0, 4'h2, 1'b0);
            if (i == 17) check("gap_before_10th", out_valid, 1'b0);
        end
        check("gap_out_valid", out_valid, 1'b1);
        check("gap_odd_cnt", odd_cnt, 4'd10);
        check("gap_even_cnt", even_cnt, 4'd0);
        check("gap_out_bus", out_bus, 40'h13579BDF13);
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);

        // flush after 6 accepts, coincident with a 7th element
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 4'h2, 1'b0);
        step(1'b0, 1'b1, 1'b1, 4'h5, 1'b0);
        check("flush_odd_cnt", odd_cnt, 4'd0);
        check("flush_even_cnt", even_cnt, 4'd0);
        check("flush_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 4'h1, 1'b0);
        check("flush_9_not_full", out_valid, 1'b0);
        step(1'b0, 1'b0, 1'b1, 4'h1, 1'b0);
        check("flush_10_full", out_valid, 1'b1);
        check("flush_out_bus", out_bus, 40'h1111111111);
        check("flush_odd_10", odd_cnt, 4'd10);
        step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);

        // reset mid-frame, then reset while FULL
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 4'h7, 1'b0);
        step(1'b1, 1'b0, 1'b1, 4'h7, 1'b0);
        check_reset_state("rst_mid");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 4'(i + 3), 1'b0);
        check("rst_full_pre", out_valid, 1'b1);
        step(1'b1, 1'b1, 1'b1, 4'h3, 1'b1);
        check_reset_state("rst_full");

        // randomized traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 2) == 0));
        end

        // N=2 instance: stream F, 0
        @(posedge clk); #1;
        rst2 = 1'b0; in_valid2 = 1'b1; in_data2 = 4'hF;
        @(posedge clk); #1;
        check("n2_after_first_valid", out_valid2, 1'b0);
        in_data2 = 4'h0;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        check("n2_out_valid", out_valid2, 1'b1);
        check("n2_in_ready", in_ready2, 1'b0);
        check("n2_out_bus", out_bus2, 8'hF0);
        check("n2_odd_cnt", odd_cnt2, 2'd1);
        check("n2_even_cnt", even_cnt2, 2'd1);
        check("n2_dbg_state", dbg_state2, 1'b1);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
